// File: rtl/edp_dot_product_sequencer_pkg.sv
// Shared types and FP32 field helpers for the EMAC dot-product sequencer.
// Pure declarations; no logic, no latency.
package edp_pkg;

   localparam int WORD_WIDTH  = 32;
   localparam int COUNT_WIDTH = 16;

   typedef enum logic [2:0] {
      CLEAR,
      ACCUM,
      FLUSH,
      CAPTURE,
      RESULT
   } seq_state_t;

   localparam int         FP32_EXP_MSB     = 30;
   localparam int         FP32_EXP_LSB     = 23;
   localparam logic [7:0] FP32_EXP_SPECIAL = 8'hFF;

   // All-ones exponent marks Inf or NaN; the EMAC result is then meaningless.
   function automatic logic is_special(input logic [31:0] w);
      return w[FP32_EXP_MSB:FP32_EXP_LSB] == FP32_EXP_SPECIAL;
   endfunction

endpackage

// File: rtl/edp_dot_product_sequencer_if.sv
// Operand stream, EMAC pin bundle and result stream of the dot-product sequencer.
// slave = the sequencer itself, master = its surroundings (source, EMAC, sink).
interface edp_dot_product_sequencer_if;
   import edp_pkg::*;

   logic                   S_Valid;
   logic                   S_Ready;
   logic [WORD_WIDTH-1:0]  S_A;
   logic [WORD_WIDTH-1:0]  S_B;
   logic                   S_Last;
   logic                   Mac_Enable;
   logic [WORD_WIDTH-1:0]  Mac_In1;
   logic [WORD_WIDTH-1:0]  Mac_In2;
   logic [WORD_WIDTH-1:0]  Mac_Out;
   logic                   M_Valid;
   logic                   M_Ready;
   logic [WORD_WIDTH-1:0]  M_Result;
   logic [COUNT_WIDTH-1:0] M_Count;
   logic                   M_Special;

   modport slave (
      input  S_Valid, S_A, S_B, S_Last, Mac_Out, M_Ready,
      output S_Ready, Mac_Enable, Mac_In1, Mac_In2, M_Valid, M_Result, M_Count, M_Special
   );

   modport master (
      output S_Valid, S_A, S_B, S_Last, Mac_Out, M_Ready,
      input  S_Ready, Mac_Enable, Mac_In1, Mac_In2, M_Valid, M_Result, M_Count, M_Special
   );

endinterface

// File: rtl/edp_dot_product_sequencer.sv
// Feeds FP32 pairs into the EMAC one vector at a time and returns the captured sum; result valid
// 2 cycles after the S_Last pair is accepted; a stalled result holds the FSM in RESULT indefinitely.
module edp_dot_product_sequencer
   import edp_pkg::*;
(
   input  logic                          Clk,
   input  logic                          Rst,
   edp_dot_product_sequencer_if.slave    bus
);

   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

   seq_state_t             state_q, state_d;
   logic [WORD_WIDTH-1:0]  in1_q, in1_d;
   logic [WORD_WIDTH-1:0]  in2_q, in2_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   spc_q, spc_d;
   logic [WORD_WIDTH-1:0]  res_q, res_d;
   logic [COUNT_WIDTH-1:0] mcnt_q, mcnt_d;
   logic                   mspc_q, mspc_d;
   logic                   mvld_q, mvld_d;
   logic                   s_hs;

   assign s_hs = bus.S_Valid && (state_q == ACCUM);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= CLEAR;
         in1_q   <= '0;
         in2_q   <= '0;
         cnt_q   <= '0;
         spc_q   <= 1'b0;
         res_q   <= '0;
         mcnt_q  <= '0;
         mspc_q  <= 1'b0;
         mvld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         cnt_q   <= cnt_d;
         spc_q   <= spc_d;
         res_q   <= res_d;
         mcnt_q  <= mcnt_d;
         mspc_q  <= mspc_d;
         mvld_q  <= mvld_d;
      end
   end

   // Operand registers default to zero: an idle cycle feeds +0*+0 into the EMAC.
   always_comb begin
      state_d = state_q;
      in1_d   = '0;
      in2_d   = '0;
      cnt_d   = cnt_q;
      spc_d   = spc_q;
      res_d   = res_q;
      mcnt_d  = mcnt_q;
      mspc_d  = mspc_q;
      mvld_d  = mvld_q;
      unique case (state_q)
         CLEAR: state_d = ACCUM;
         ACCUM: begin
            if (s_hs) begin
               in1_d = bus.S_A;
               in2_d = bus.S_B;
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
               spc_d = spc_q | is_special(bus.S_A) | is_special(bus.S_B);
               if (bus.S_Last) state_d = FLUSH;
            end
         end
         FLUSH: state_d = CAPTURE;
         CAPTURE: begin
            res_d   = bus.Mac_Out;
            mcnt_d  = cnt_q;
            mspc_d  = spc_q;
            mvld_d  = 1'b1;
            state_d = RESULT;
         end
         RESULT: begin
            if (bus.M_Ready) begin
               mvld_d  = 1'b0;
               cnt_d   = '0;
               spc_d   = 1'b0;
               state_d = ACCUM;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   // Enable low in CLEAR/RESULT (and in reset) wipes the EMAC between vectors.
   assign bus.Mac_Enable = (state_q == ACCUM) || (state_q == FLUSH) || (state_q == CAPTURE);
   assign bus.S_Ready    = (state_q == ACCUM);
   assign bus.Mac_In1    = in1_q;
   assign bus.Mac_In2    = in2_q;
   assign bus.M_Valid    = mvld_q;
   assign bus.M_Result   = res_q;
   assign bus.M_Count    = mcnt_q;
   assign bus.M_Special  = mspc_q;

endmodule

// File: tb/tb_edp_dot_product_sequencer.sv
// Bench: sequencer beside a behavioural EMAC; a per-vector sum/count/flag scoreboard checks every
// accepted result, and directed tests pin literal values, latency, backpressure and reset.
module tb_edp_dot_product_sequencer;
   import edp_pkg::*;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   always #5 Clk = ~Clk;

   edp_dot_product_sequencer_if bus();

   edp_dot_product_sequencer dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   function automatic real f2r(input logic [31:0] w);
      int          e;
      logic [63:0] d;
      if (w[30:0] == 31'd0) return 0.0;
      e = int'(w[30:23]) + 896;
      d = {w[31], e[10:0], w[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      int          e;
      logic [63:0] d;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      e = int'(d[62:52]) - 896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic bit spec(input logic [31:0] w);
      return w[30:23] == 8'hFF;
   endfunction

   // Behavioural EMAC: registered accumulator, cleared while Enable is low.
   real acc;
   always @(posedge Clk or posedge Rst) begin
      if (Rst || !bus.Mac_Enable) acc <= 0.0;
      else acc <= acc + f2r(bus.Mac_In1) * f2r(bus.Mac_In2);
   end
   always @* bus.Mac_Out = r2f(acc);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: one entry per completed vector.
   real         vec_sum = 0.0;
   int          vec_cnt = 0;
   bit          vec_spc = 1'b0;
   logic [31:0] q_res[$];
   int          q_cnt[$];
   bit          q_spc[$];

   logic [31:0] last_res;
   logic [15:0] last_cnt;
   logic        last_spc;
   int          n_seen = 0;

   always @(negedge Clk) begin
      if (!Rst && bus.M_Valid && bus.M_Ready) begin
         if (q_res.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got result %h with no vector outstanding", bus.M_Result);
         end else begin
            if (!q_spc[0]) chk("sb_result", bus.M_Result, q_res[0]);
            chk("sb_count", 32'(bus.M_Count), 32'(q_cnt[0]));
            chk("sb_special", 32'(bus.M_Special), 32'(q_spc[0]));
            void'(q_res.pop_front());
            void'(q_cnt.pop_front());
            void'(q_spc.pop_front());
         end
         last_res = bus.M_Result;
         last_cnt = bus.M_Count;
         last_spc = bus.M_Special;
         n_seen++;
      end
   end

   task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input logic last);
      int t = 0;
      @(negedge Clk);
      bus.S_Valid = 1'b1;
      bus.S_A     = a;
      bus.S_B     = b;
      bus.S_Last  = last;
      while (!bus.S_Ready && t < 50) begin
         @(negedge Clk);
         t++;
      end
      if (!bus.S_Ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: S_Ready got 0 expected 1 within 50 cycles");
      end
      @(posedge Clk);
      #1;
      bus.S_Valid = 1'b0;
      vec_sum += f2r(a) * f2r(b);
      vec_cnt++;
      vec_spc |= spec(a) | spec(b);
      if (last) begin
         q_res.push_back(r2f(vec_sum));
         q_cnt.push_back(vec_cnt);
         q_spc.push_back(vec_spc);
         vec_sum = 0.0;
         vec_cnt = 0;
         vec_spc = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic wait_result(input string name, input int target, input logic [31:0] res,
                              input int cnt, input bit spc, input bit chk_res);
      int t = 0;
      while (n_seen < target && t < 100) begin
         @(negedge Clk);
         t++;
      end
      #1;
      chk({name, "_seen"}, 32'(n_seen), 32'(target));
      if (chk_res) chk({name, "_result"}, last_res, res);
      chk({name, "_count"}, 32'(last_cnt), 32'(cnt));
      chk({name, "_special"}, 32'(last_spc), 32'(spc));
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_mac_en"}, 32'(bus.Mac_Enable), 32'd0);
      chk({name, "_s_ready"}, 32'(bus.S_Ready), 32'd0);
      chk({name, "_mac_in1"}, bus.Mac_In1, 32'd0);
      chk({name, "_mac_in2"}, bus.Mac_In2, 32'd0);
      chk({name, "_m_valid"}, 32'(bus.M_Valid), 32'd0);
      chk({name, "_m_result"}, bus.M_Result, 32'd0);
      chk({name, "_m_count"}, 32'(bus.M_Count), 32'd0);
      chk({name, "_m_special"}, 32'(bus.M_Special), 32'd0);
   endtask

   initial begin
      int          n;
      int          tgt;
      logic [31:0] r0;
      logic [15:0] c0;
      logic        p0;

      bus.S_Valid = 1'b0;
      bus.S_A     = '0;
      bus.S_B     = '0;
      bus.S_Last  = 1'b0;
      bus.M_Ready = 1'b1;
      tgt         = 0;

      #12;
      check_reset_outputs("reset");
      @(negedge Clk);
      Rst = 1'b0;

      // 1: two pairs, latency from S_Last acceptance to M_Valid
      send_pair(32'h3F800000, 32'h40000000, 1'b0);
      send_pair(32'h40400000, 32'h40800000, 1'b1);
      n = 0;
      while (n < 6) begin
         @(posedge Clk);
         #1;
         n++;
         if (bus.M_Valid) break;
      end
      chk("t1_latency", 32'(n), 32'd2);
      tgt++;
      wait_result("t1", tgt, 32'h41600000, 2, 1'b0, 1'b1);

      // 2: single pair, then back-to-back vector proving the clear
      send_pair(32'h40000000, 32'hC0400000, 1'b1);
      send_pair(32'h3F800000, 32'h3F800000, 1'b1);
      tgt++;
      wait_result("t2a", tgt, 32'hC0C00000, 1, 1'b0, 1'b1);
      tgt++;
      wait_result("t2b", tgt, 32'h3F800000, 1, 1'b0, 1'b1);

      // 3: bubbles between pairs
      send_pair(32'h3F800000, 32'h3F800000, 1'b0);
      idle(2);
      send_pair(32'h3F800000, 32'h3F800000, 1'b1);
      tgt++;
      wait_result("t3", tgt, 32'h40000000, 2, 1'b0, 1'b1);

      // 4: backpressure holds the result and blocks the input
      @(posedge Clk);
      #1;
      bus.M_Ready = 1'b0;
      send_pair(32'h40000000, 32'h40000000, 1'b1);
      n = 0;
      while (!bus.M_Valid && n < 20) begin
         @(negedge Clk);
         n++;
      end
      chk("t4_valid_rise", 32'(bus.M_Valid), 32'd1);
      r0 = bus.M_Result;
      c0 = bus.M_Count;
      p0 = bus.M_Special;
      chk("t4_held_value", r0, 32'h40800000);
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         chk("t4_hold_valid", 32'(bus.M_Valid), 32'd1);
         chk("t4_hold_result", bus.M_Result, r0);
         chk("t4_hold_count", 32'(bus.M_Count), 32'(c0));
         chk("t4_hold_special", 32'(bus.M_Special), 32'(p0));
         chk("t4_hold_s_ready", 32'(bus.S_Ready), 32'd0);
      end
      @(posedge Clk);
      #1;
      bus.M_Ready = 1'b1;
      @(posedge Clk);
      #1;
      chk("t4_accum_s_ready", 32'(bus.S_Ready), 32'd1);
      chk("t4_accum_m_valid", 32'(bus.M_Valid), 32'd0);
      tgt++;
      wait_result("t4", tgt, 32'h40800000, 1, 1'b0, 1'b1);

      // 5: Inf operand flags the vector; next vector clean
      send_pair(32'h7F800000, 32'h3F800000, 1'b0);
      send_pair(32'h3F800000, 32'h3F800000, 1'b0);
      send_pair(32'h3F800000, 32'h3F800000, 1'b1);
      tgt++;
      wait_result("t5a", tgt, 32'h0, 3, 1'b1, 1'b0);
      send_pair(32'h3F800000, 32'h3F800000, 1'b1);
      tgt++;
      wait_result("t5b", tgt, 32'h3F800000, 1, 1'b0, 1'b1);

      // 6: reset while in FLUSH discards the vector
      send_pair(32'h3F800000, 32'h3F800000, 1'b0);
      send_pair(32'h40000000, 32'h40000000, 1'b1);
      chk("t6_in_flush_mac_in1", bus.Mac_In1, 32'h40000000);
      #2;
      Rst = 1'b1;
      #1;
      check_reset_outputs("t6_async");
      void'(q_res.pop_back());
      void'(q_cnt.pop_back());
      void'(q_spc.pop_back());
      @(negedge Clk);
      Rst = 1'b0;
      send_pair(32'h3F800000, 32'h40A00000, 1'b1);
      tgt++;
      wait_result("t6", tgt, 32'h40A00000, 1, 1'b0, 1'b1);

      idle(3);
      chk("sb_drained", 32'(q_res.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
